// File: rtl/bkm_csd2bin_if.sv
// Handshake and data bundle between bkm_steps (CSD words in) and the
// result formatter (two's-complement words out).
interface bkm_csd2bin_if #(
  parameter int WD = 72
);
  logic            in_valid;
  logic            in_ready;
  logic [2*WD-1:0] X_in_csd;
  logic [2*WD-1:0] Y_in_csd;
  logic            out_valid;
  logic            out_ready;
  logic [WD:0]     X_out_bin;
  logic [WD:0]     Y_out_bin;
  logic            out_err;

  modport master (
    output in_valid, X_in_csd, Y_in_csd, out_ready,
    input  in_ready, out_valid, X_out_bin, Y_out_bin, out_err
  );

  modport slave (
    input  in_valid, X_in_csd, Y_in_csd, out_ready,
    output in_ready, out_valid, X_out_bin, Y_out_bin, out_err
  );
endinterface

// File: rtl/bkm_csd2bin_pipe.sv
// CSD-to-binary converter: X and Y are each reduced to P - N with an NS-stage
// carry-pipelined adder; valid/err bits ride alongside the data.
module bkm_csd2bin_pipe #(
  parameter int WD = 72,
  parameter int NS = 3
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         srst,
  input  logic         enable,
  bkm_csd2bin_if.slave bus
);
  // ceil((WD+1)/NS); the last chunk takes whatever bits remain.
  localparam int CW = (WD + NS) / NS;

  logic            w_advance;
  logic [2*WD-1:0] w_csd [2];
  logic [WD:0]     w_p   [2];
  logic [WD:0]     w_nb  [2];
  logic [1:0]      w_bad;

  assign w_advance    = enable & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = w_advance;
  assign w_csd[0]     = bus.X_in_csd;
  assign w_csd[1]     = bus.Y_in_csd;

  // NOTE: every always_comb output gets a default before the loop; a bit left
  // unassigned on some path would otherwise be held by an inferred latch.
  always_comb begin
    w_bad = '0;
    for (int w = 0; w < 2; w++) begin
      w_p[w]  = '0;
      w_nb[w] = '1;
      for (int i = 0; i < WD; i++) begin
        w_p[w][i]  = (w_csd[w][2*i +: 2] == 2'b01);
        w_nb[w][i] = (w_csd[w][2*i +: 2] != 2'b10);
        w_bad[w]   = w_bad[w] | (w_csd[w][2*i +: 2] == 2'b11);
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int LO = s * CW;
    localparam int HI = (s == NS - 1) ? WD : LO + CW - 1;
    localparam int W  = HI - LO + 1;

    logic [HI:LO] w_a     [2];
    logic [HI:LO] w_b     [2];
    logic [HI:LO] w_sum   [2];
    logic [HI:0]  w_s_nxt [2];
    logic [1:0]   w_ci;
    logic         w_vi;
    logic         w_ei;
    logic [HI:0]  r_s [2];
    logic         r_v;
    logic         r_e;

    if (s == 0) begin : g_src
      always_comb begin
        for (int w = 0; w < 2; w++) begin
          w_a[w] = w_p[w][HI:0];
          w_b[w] = w_nb[w][HI:0];
        end
      end
      always_comb begin
        for (int w = 0; w < 2; w++) w_s_nxt[w] = w_sum[w];
      end
      // P + ~N + 1: the +1 enters as the carry-in of the lowest chunk.
      assign w_ci = 2'b11;
      assign w_vi = bus.in_valid;
      assign w_ei = bus.in_valid & (|w_bad);
    end else begin : g_src
      always_comb begin
        for (int w = 0; w < 2; w++) begin
          w_a[w] = g_stage[s-1].g_fwd.r_a[w][HI:LO];
          w_b[w] = g_stage[s-1].g_fwd.r_b[w][HI:LO];
        end
      end
      always_comb begin
        for (int w = 0; w < 2; w++) w_s_nxt[w] = {w_sum[w], g_stage[s-1].r_s[w]};
      end
      assign w_ci = g_stage[s-1].g_fwd.r_c;
      assign w_vi = g_stage[s-1].r_v;
      assign w_ei = g_stage[s-1].r_e;
    end

    if (s < NS - 1) begin : g_fwd
      logic [1:0]     w_co;
      logic [WD:HI+1] w_ra [2];
      logic [WD:HI+1] w_rb [2];
      logic [1:0]     r_c;
      logic [WD:HI+1] r_a [2];
      logic [WD:HI+1] r_b [2];

      always_comb begin
        for (int w = 0; w < 2; w++)
          {w_co[w], w_sum[w]} = {1'b0, w_a[w]} + {1'b0, w_b[w]} + (W+1)'(w_ci[w]);
      end

      if (s == 0) begin : g_rest
        always_comb begin
          for (int w = 0; w < 2; w++) begin
            w_ra[w] = w_p[w][WD:HI+1];
            w_rb[w] = w_nb[w][WD:HI+1];
          end
        end
      end else begin : g_rest
        always_comb begin
          for (int w = 0; w < 2; w++) begin
            w_ra[w] = g_stage[s-1].g_fwd.r_a[w][WD:HI+1];
            w_rb[w] = g_stage[s-1].g_fwd.r_b[w][WD:HI+1];
          end
        end
      end

      // NOTE: registers use non-blocking assignments so every stage samples
      // its neighbour's pre-edge value and the shift happens in lock-step.
      always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
          r_c <= '0;
          for (int w = 0; w < 2; w++) begin
            r_a[w] <= '0;
            r_b[w] <= '0;
          end
        end else if (srst) begin
          r_c <= '0;
          for (int w = 0; w < 2; w++) begin
            r_a[w] <= '0;
            r_b[w] <= '0;
          end
        end else if (w_advance) begin
          r_c <= w_co;
          for (int w = 0; w < 2; w++) begin
            r_a[w] <= w_ra[w];
            r_b[w] <= w_rb[w];
          end
        end
      end
    end else begin : g_last
      // Carry out of the top chunk is discarded: the result cannot overflow.
      always_comb begin
        for (int w = 0; w < 2; w++) w_sum[w] = w_a[w] + w_b[w] + W'(w_ci[w]);
      end
    end

    // NOTE: the data registers are reset along with the valid bits so the
    // outputs read as zero after any reset, not just out_valid.
    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        r_v <= 1'b0;
        r_e <= 1'b0;
        for (int w = 0; w < 2; w++) r_s[w] <= '0;
      end else if (srst) begin
        r_v <= 1'b0;
        r_e <= 1'b0;
        for (int w = 0; w < 2; w++) r_s[w] <= '0;
      end else if (w_advance) begin
        r_v <= w_vi;
        r_e <= w_ei;
        for (int w = 0; w < 2; w++) r_s[w] <= w_s_nxt[w];
      end
    end
  end

  assign bus.out_valid = g_stage[NS-1].r_v;
  assign bus.out_err   = g_stage[NS-1].r_e;
  assign bus.X_out_bin = g_stage[NS-1].r_s[0];
  assign bus.Y_out_bin = g_stage[NS-1].r_s[1];

endmodule

// File: tb/tb_bkm_csd2bin_pipe.sv
// Bench for bkm_csd2bin_pipe (WD=8, NS=3): directed vector table, reset and
// backpressure sequences, then random traffic against a digit-sum model.
module tb_bkm_csd2bin_pipe;
  localparam int WD = 8;
  localparam int NS = 3;

  typedef struct packed {
    logic [WD:0] x;
    logic [WD:0] y;
    logic        e;
  } res_t;

  typedef struct {
    logic [2*WD-1:0] x;
    logic [2*WD-1:0] y;
    logic [WD:0]     ex;
    logic [WD:0]     ey;
    logic            ee;
  } vec_t;

  logic clk = 1'b0;
  logic arst;
  logic srst;
  logic enable;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_acc  = 0;
  int   n_pop  = 0;
  bit   sb_on  = 1'b0;
  res_t sb [$];
  bit   held_v = 1'b0;
  res_t held_r;
  logic mon_adv;
  res_t mon_exp;
  vec_t tbl [7];

  bkm_csd2bin_if #(.WD(WD)) bus ();

  bkm_csd2bin_pipe #(.WD(WD), .NS(NS)) dut (
    .clk    (clk),
    .arst   (arst),
    .srst   (srst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int digit(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  // Reference: value = sum(d_i * 2^i), illegal digits count as 0 and flag err.
  function automatic res_t ref_value(input logic [2*WD-1:0] x, input logic [2*WD-1:0] y);
    int   vx;
    int   vy;
    res_t r;
    vx  = 0;
    vy  = 0;
    r.e = 1'b0;
    for (int i = 0; i < WD; i++) begin
      vx  += digit(x[2*i +: 2]) * (1 << i);
      vy  += digit(y[2*i +: 2]) * (1 << i);
      r.e |= (x[2*i +: 2] == 2'b11) | (y[2*i +: 2] == 2'b11);
    end
    r.x = (WD+1)'(vx);
    r.y = (WD+1)'(vy);
    return r;
  endfunction

  function automatic logic [2*WD-1:0] rand_csd();
    logic [2*WD-1:0] r;
    for (int i = 0; i < WD; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (sb_on) begin
      mon_adv = enable & (~bus.out_valid | bus.out_ready);
      check("in_ready", bus.in_ready, mon_adv);
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_x", bus.X_out_bin, held_r.x);
        check("hold_y", bus.Y_out_bin, held_r.y);
        check("hold_err", bus.out_err, held_r.e);
      end
      held_v = bus.out_valid & ~mon_adv & ~srst;
      held_r = '{x: bus.X_out_bin, y: bus.Y_out_bin, e: bus.out_err};
      if (bus.out_valid & mon_adv) begin
        if (sb.size() == 0) begin
          check("spurious_out", bus.out_valid, 1'b0);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_x", bus.X_out_bin, mon_exp.x);
          check("sb_y", bus.Y_out_bin, mon_exp.y);
          check("sb_err", bus.out_err, mon_exp.e);
          n_pop++;
        end
      end
      if (bus.in_valid & mon_adv & ~srst) begin
        sb.push_back(ref_value(bus.X_in_csd, bus.Y_in_csd));
        n_acc++;
      end
      if (srst) sb.delete();
    end else begin
      held_v = 1'b0;
    end
  end

  // Call at posedge+1 with an empty pipeline and out_ready=1.
  task automatic send_check(input logic [2*WD-1:0] x, input logic [2*WD-1:0] y,
                            input logic [WD:0] ex, input logic [WD:0] ey,
                            input logic ee, input string tag);
    int lat;
    lat = -1;
    bus.X_in_csd = x;
    bus.Y_in_csd = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = t;
        break;
      end
    end
    check({tag, " latency"}, lat, NS - 1);
    check({tag, " x"}, bus.X_out_bin, ex);
    check({tag, " y"}, bus.Y_out_bin, ey);
    check({tag, " err"}, bus.out_err, ee);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input bit toggle);
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      bus.out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    check(name, sb.size(), 0);
  endtask

  initial begin
    int   base;
    int   target;
    res_t r;

    tbl[0] = '{x: 16'h4002, y: 16'h8000, ex: 9'h07F, ey: 9'h180, ee: 1'b0};
    tbl[1] = '{x: 16'h5555, y: 16'hAAAA, ex: 9'h0FF, ey: 9'h101, ee: 1'b0};
    tbl[2] = '{x: 16'h0000, y: 16'h0000, ex: 9'h000, ey: 9'h000, ee: 1'b0};
    tbl[3] = '{x: 16'h00C0, y: 16'h0000, ex: 9'h000, ey: 9'h000, ee: 1'b1};
    tbl[4] = '{x: 16'h0001, y: 16'h0002, ex: 9'h001, ey: 9'h1FF, ee: 1'b0};
    tbl[5] = '{x: 16'h0005, y: 16'hC000, ex: 9'h003, ey: 9'h000, ee: 1'b1};
    tbl[6] = '{x: 16'h0006, y: 16'h0009, ex: 9'h001, ey: 9'h1FF, ee: 1'b0};

    arst          = 1'b0;
    srst          = 1'b0;
    enable        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.X_in_csd  = '0;
    bus.Y_in_csd  = '0;

    @(negedge clk);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst x", bus.X_out_bin, '0);
    check("rst y", bus.Y_out_bin, '0);
    check("rst err", bus.out_err, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      send_check(tbl[i].x, tbl[i].y, tbl[i].ex, tbl[i].ey, tbl[i].ee, $sformatf("vec%0d", i));

    // Asynchronous reset with three words in flight.
    for (int j = 0; j < 3; j++) begin
      bus.X_in_csd = rand_csd();
      bus.Y_in_csd = rand_csd();
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    arst = 1'b0;
    #2;
    check("arst out_valid", bus.out_valid, 1'b0);
    check("arst x", bus.X_out_bin, '0);
    check("arst y", bus.Y_out_bin, '0);
    check("arst in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("no_stale", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
    bus.X_in_csd = rand_csd();
    bus.Y_in_csd = rand_csd();
    r = ref_value(bus.X_in_csd, bus.Y_in_csd);
    send_check(bus.X_in_csd, bus.Y_in_csd, r.x, r.y, r.e, "post_rst");

    // Back-to-back throughput with the scoreboard live.
    sb_on = 1'b1;
    base  = n_acc;
    for (int j = 0; j < 6; j++) begin
      bus.X_in_csd = rand_csd();
      bus.Y_in_csd = rand_csd();
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("throughput", n_acc - base, 6);
    drain("tput_drain", 1'b0);

    // Eight words under random out_ready, enable low for two cycles.
    base = n_pop;
    for (int j = 0; j < 8; j++) begin
      bus.X_in_csd = rand_csd();
      bus.Y_in_csd = rand_csd();
      bus.in_valid = 1'b1;
      target = n_acc + 1;
      for (int t = 0; t < 64 && n_acc < target; t++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        enable        = !(j == 4 && t < 2);
        @(posedge clk); #1;
      end
      check("bp_accept", n_acc, target);
    end
    bus.in_valid = 1'b0;
    enable       = 1'b1;
    drain("bp_drain", 1'b1);
    check("bp_count", n_pop - base, 8);

    // Random legal traffic with occasional synchronous clears.
    base = n_acc;
    for (int c = 0; c < 40000 && (n_acc - base) < 10000; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) != 0);
      bus.X_in_csd  = rand_csd();
      bus.Y_in_csd  = rand_csd();
      bus.out_ready = ($urandom_range(0, 4) != 0);
      enable        = ($urandom_range(0, 19) != 0);
      srst          = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    srst         = 1'b0;
    enable       = 1'b1;
    bus.in_valid = 1'b0;
    check("random_words", (n_acc - base) >= 10000, 1'b1);
    drain("final_drain", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
